// File: rtl/round_tweakey_seq_pkg.sv
// Shared constants for the SKINNY-128-384+ round tweakey sequencer:
// round count, tweakey cell permutation, round-constant seed and FSM encoding.
package round_tweakey_seq_pkg;

  localparam int NR_DEFAULT = 40;

  localparam logic [5:0] RC_INIT = 6'h01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Output cell i of the tweakey permutation takes input cell PT_TABLE[i].
  localparam logic [3:0] PT_TABLE [16] = '{
    4'd9, 4'd15, 4'd8, 4'd13, 4'd10, 4'd14, 4'd12, 4'd11,
    4'd0, 4'd1,  4'd2, 4'd3,  4'd4,  4'd5,  4'd6,  4'd7
  };

  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    rc_step = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/TweakPerm.sv
// Tweakey cell permutation PT: pure wiring, cell 0 in the most significant W bits.
module TweakPerm
  import round_tweakey_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [16*W-1:0] tk_in,
  output logic [16*W-1:0] tk_out
);

  for (genvar i = 0; i < 16; i++) begin : g_cell
    localparam int SRC = int'(PT_TABLE[i]);
    assign tk_out[(15-i)*W +: W] = tk_in[(15-SRC)*W +: W];
  end

endmodule

// File: rtl/round_tweakey_seq_lfsr3.sv
// TK3 cell LFSR: (x7..x0) -> (x0^x6, x7..x1), generalised to a W-bit cell.
module LFSR3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] cell_in,
  output logic [W-1:0] cell_out
);

  assign cell_out = {cell_in[0] ^ cell_in[W-2], cell_in[W-1:1]};

endmodule

// File: rtl/round_tweakey_seq.sv
// Round tweakey sequencer: holds TK1/TK3, steps them per accepted round key and
// combines them with the external TK2 register and the round constant.
module round_tweakey_seq
  import round_tweakey_seq_pkg::*;
#(
  parameter int NR = NR_DEFAULT,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] TK1_init,
  input  logic [127:0] TK3_init,
  input  logic [127:0] TK2_rounding,
  output logic         TK2_sel,
  output logic         TK2_en,
  output logic [63:0]  rtk,
  output logic         rtk_valid,
  input  logic         rtk_ready,
  output logic [5:0]   round_idx,
  output logic         last_round,
  output logic         busy
);

  localparam logic [5:0] LAST_IDX = 6'(NR - 1);

  logic [1:0]   state_r;
  logic [127:0] tk1_r;
  logic [127:0] tk3_r;
  logic [5:0]   rc_r;
  logic [5:0]   round_idx_r;

  logic [127:0] tk1_next_s;
  logic [127:0] tk3_perm_s;
  logic [127:0] tk3_next_s;
  logic         run_s;
  logic         last_s;
  logic         fire_s;
  logic [63:0]  rc_mask_s;
  logic         unused_s;

  TweakPerm #(.W(W)) u_pt1 (.tk_in(tk1_r), .tk_out(tk1_next_s));
  TweakPerm #(.W(W)) u_pt3 (.tk_in(tk3_r), .tk_out(tk3_perm_s));

  for (genvar i = 0; i < 8; i++) begin : g_lfsr3
    LFSR3 #(.W(W)) u_lfsr3 (
      .cell_in  (tk3_perm_s[(15-i)*W +: W]),
      .cell_out (tk3_next_s[(15-i)*W +: W])
    );
  end
  assign tk3_next_s[8*W-1:0] = tk3_perm_s[8*W-1:0];

  // The bottom half of TK2 never reaches this round's key.
  assign unused_s = ^TK2_rounding[63:0];

  // Handshake and round qualification.
  always_comb begin
    run_s  = (state_r == ST_RUN);
    last_s = run_s && (round_idx_r == LAST_IDX);
    fire_s = run_s && rtk_ready;
  end

  // Row-0 and row-1 round constants; the row-2 constant is left to the consumer.
  always_comb begin
    rc_mask_s = {4'h0, rc_r[3:0], 24'h0, 6'h0, rc_r[5:4], 24'h0};
  end

  // Output decode; the final fire retires the run without stepping TK2.
  always_comb begin
    TK2_sel    = 1'b0;
    TK2_en     = 1'b0;
    rtk        = 64'h0;
    rtk_valid  = run_s;
    last_round = last_s;
    busy       = (state_r != ST_IDLE);
    round_idx  = round_idx_r;
    if (state_r == ST_LOAD) begin
      TK2_sel = 1'b1;
      TK2_en  = 1'b1;
    end else if (fire_s && !last_s) begin
      TK2_en = 1'b1;
    end else begin
      TK2_en = 1'b0;
    end
    if (run_s) begin
      rtk = tk1_r[127:64] ^ TK2_rounding[127:64] ^ tk3_r[127:64] ^ rc_mask_s;
    end else begin
      rtk = 64'h0;
    end
  end

  // FSM and tweakey state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      tk1_r       <= 128'h0;
      tk3_r       <= 128'h0;
      rc_r        <= 6'h0;
      round_idx_r <= 6'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tk1_r       <= TK1_init;
          tk3_r       <= TK3_init;
          rc_r        <= RC_INIT;
          round_idx_r <= 6'h0;
          state_r     <= ST_RUN;
        end
        ST_RUN: begin
          if (fire_s) begin
            if (last_s) begin
              state_r <= ST_IDLE;
            end else begin
              tk1_r       <= tk1_next_s;
              tk3_r       <= tk3_next_s;
              rc_r        <= rc_step(rc_r);
              round_idx_r <= round_idx_r + 6'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_tweakey_seq.sv
// Directed bench for round_tweakey_seq: table of hand-computed round keys plus
// stall, full-run, mid-run reset and ignored-start sequences.
module tb_round_tweakey_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] TK1_init;
  logic [127:0] TK3_init;
  logic [127:0] TK2_rounding;
  logic         TK2_sel;
  logic         TK2_en;
  logic [63:0]  rtk;
  logic         rtk_valid;
  logic         rtk_ready;
  logic [5:0]   round_idx;
  logic         last_round;
  logic         busy;

  int checks;
  int failures;

  round_tweakey_seq #(.NR(40), .W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .TK1_init     (TK1_init),
    .TK3_init     (TK3_init),
    .TK2_rounding (TK2_rounding),
    .TK2_sel      (TK2_sel),
    .TK2_en       (TK2_en),
    .rtk          (rtk),
    .rtk_valid    (rtk_valid),
    .rtk_ready    (rtk_ready),
    .round_idx    (round_idx),
    .last_round   (last_round),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] tk1;
    logic [127:0] tk3;
    logic [127:0] tk2;
    logic [5:0]   round;
    logic [63:0]  exp_rtk;
  } vec_t;

  vec_t vecs [10];

  localparam logic [127:0] SEQ = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] T2  = 128'h11223344556677880000000000000000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge showing round 0.
  task automatic start_run(input logic [127:0] t1, input logic [127:0] t3);
    TK1_init = t1;
    TK3_init = t3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_sel", {63'h0, TK2_sel}, 64'h1);
    chk("load_en", {63'h0, TK2_en}, 64'h1);
    chk("load_valid", {63'h0, rtk_valid}, 64'h0);
    @(negedge clk);
    chk("first_valid", {63'h0, rtk_valid}, 64'h1);
    chk("first_idx", {58'h0, round_idx}, 64'h0);
  endtask

  task automatic wait_round(input logic [5:0] r);
    int n;
    n = 0;
    while (!(rtk_valid && round_idx == r) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL wait_round actual=timeout expected=round %0d", r);
    end
  endtask

  function automatic logic [63:0] rc_mask(input logic [5:0] rc);
    rc_mask = {4'h0, rc[3:0], 24'h0, 6'h0, rc[5:4], 24'h0};
  endfunction

  initial begin
    logic [5:0] exp_rc;
    int nvalid;
    checks = 0;
    failures = 0;
    start = 1'b0;
    rtk_ready = 1'b1;
    TK1_init = 128'h0;
    TK3_init = 128'h0;
    TK2_rounding = 128'h0;

    vecs[0] = '{128'h0, 128'h0, 128'h0, 6'd0, 64'h0100000000000000};
    vecs[1] = '{128'h0, 128'h0, 128'h0, 6'd5, 64'h0E00000003000000};
    vecs[2] = '{SEQ,    128'h0, 128'h0, 6'd1, 64'h0A0F080D0A0E0C0B};
    vecs[3] = '{SEQ,    128'h0, 128'h0, 6'd0, 64'h0101020304050607};
    vecs[4] = '{128'h0, SEQ,    128'h0, 6'd1, 64'h8787048605070685};
    vecs[5] = '{128'h0, 128'h0, T2,     6'd0, 64'h1022334455667788};
    vecs[6] = '{128'h0, SEQ,    128'h0, 6'd0, 64'h0101020304050607};
    vecs[7] = '{SEQ,    SEQ,    128'h0, 6'd1, 64'h8E880C8B0F090A8E};
    vecs[8] = '{SEQ,    128'h0, 128'h0, 6'd2, 64'h0607000502060403};
    vecs[9] = '{128'h0, 128'h0, T2,     6'd3, 64'h1E22334455667788};

    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_valid", {63'h0, rtk_valid}, 64'h0);
    chk("rst_rtk", rtk, 64'h0);
    chk("rst_idx", {58'h0, round_idx}, 64'h0);
    chk("rst_en_sel", {62'h0, TK2_en, TK2_sel}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      TK2_rounding = vecs[v].tk2;
      rtk_ready = 1'b1;
      start_run(vecs[v].tk1, vecs[v].tk3);
      wait_round(vecs[v].round);
      chk($sformatf("vec%0d_rtk", v), rtk, vecs[v].exp_rtk);
    end

    // Stall three cycles in round 2.
    do_reset();
    TK2_rounding = 128'h0;
    rtk_ready = 1'b1;
    start_run(SEQ, 128'h0);
    wait_round(6'd2);
    rtk_ready = 1'b0;
    #1;
    chk("stall_en0", {63'h0, TK2_en}, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_rtk", rtk, 64'h0607000502060403);
      chk("stall_idx", {58'h0, round_idx}, 64'd2);
      chk("stall_en", {63'h0, TK2_en}, 64'h0);
    end
    rtk_ready = 1'b1;
    #1;
    chk("fire_en", {63'h0, TK2_en}, 64'h1);
    chk("fire_sel", {63'h0, TK2_sel}, 64'h0);
    @(negedge clk);
    chk("resume_idx", {58'h0, round_idx}, 64'd3);

    // Full run with zero keys; start pulsed mid-run and on the final fire.
    do_reset();
    start_run(128'h0, 128'h0);
    exp_rc = 6'h01;
    nvalid = 0;
    for (int c = 0; c < 60 && rtk_valid; c++) begin
      chk("full_rtk", rtk, rc_mask(exp_rc));
      chk("full_idx", {58'h0, round_idx}, 64'(nvalid));
      chk("full_last", {63'h0, last_round}, (nvalid == 39) ? 64'h1 : 64'h0);
      chk("full_sel", {63'h0, TK2_sel}, 64'h0);
      start = (round_idx == 6'd20 || round_idx == 6'd39) ? 1'b1 : 1'b0;
      nvalid++;
      exp_rc = {exp_rc[4:0], exp_rc[5] ^ exp_rc[4] ^ 1'b1};
      @(negedge clk);
    end
    start = 1'b0;
    chk("full_count", 64'(nvalid), 64'd40);
    chk("full_done_busy", {63'h0, busy}, 64'h0);
    chk("full_done_sel", {63'h0, TK2_sel}, 64'h0);
    @(negedge clk);
    chk("no_load_busy", {63'h0, busy}, 64'h0);
    chk("no_load_sel", {63'h0, TK2_sel}, 64'h0);

    // Reset at round 10, then restart.
    start_run(SEQ, SEQ);
    wait_round(6'd10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_valid", {63'h0, rtk_valid}, 64'h0);
    chk("mid_rst_rtk", rtk, 64'h0);
    chk("mid_rst_en_sel", {62'h0, TK2_en, TK2_sel}, 64'h0);
    chk("mid_rst_idx", {58'h0, round_idx}, 64'h0);
    chk("mid_rst_last", {63'h0, last_round}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {63'h0, busy}, 64'h0);
    start_run(128'h0, 128'h0);
    chk("restart_rtk", rtk, 64'h0100000000000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_tweakey_seq.md
ROUND_TWEAKEY_SEQ -- requirements
Module: round_tweakey_seq

Interface
REQ-001 The block SHALL have parameter NR, default 40, meaning the number of SKINNY-128-384+ rounds per run, with NR >= 1.
REQ-002 The block SHALL have parameter W, default 8, meaning the cell width in bits.
REQ-003 The block SHALL have a single clock; reset SHALL be synchronous and active-low.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port start, input, 1 bit: request to begin a run; sampled only in IDLE.
REQ-007 Port TK1_init, input, 128 bits: initial TK1, cell 0 at bits 127:120.
REQ-008 Port TK3_init, input, 128 bits: initial TK3.
REQ-009 Port TK2_rounding, input, 128 bits: current TK2 from the TK2 rounding register.
REQ-010 Port TK2_sel, output, 1 bit: select input of the TK2 rounding register (1 loads TK2_init).
REQ-011 Port TK2_en, output, 1 bit: enable input of the TK2 rounding register.
REQ-012 Port rtk, output, 64 bits: round tweakey with round constants applied.
REQ-013 Port rtk_valid, output, 1 bit: rtk holds the key for round round_idx.
REQ-014 Port rtk_ready, input, 1 bit: the consumer accepts rtk this cycle.
REQ-015 Port round_idx, output, 6 bits: current round number.
REQ-016 Port last_round, output, 1 bit: the current round is round NR-1.
REQ-017 Port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD, RUN.
REQ-019 IDLE SHALL go to LOAD when start=1; start SHALL be ignored in LOAD and RUN.
REQ-020 LOAD SHALL last one cycle, with TK2_sel=1 and TK2_en=1; it SHALL load TK1 and TK3 from their inputs, set rc to 6'h01 and round_idx to 0, then go to RUN.
REQ-021 In RUN, rtk_valid SHALL be 1, and a handshake ("fire") SHALL be rtk_valid & rtk_ready.
REQ-022 On fire the block SHALL, in the same cycle:
- TK1 <= PT(TK1)
- TK3 <= PT(TK3) with LFSR3 applied to cells 0..7
- TK2_en=1, TK2_sel=0
- rc <= {rc[4:0], rc[5]^rc[4]^1}
- round_idx++
REQ-023 PT SHALL map output cell i to input cell P[i], with P = 9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7.
REQ-024 LFSR3 SHALL map (x7..x0) to (x0^x6, x7..x1).
REQ-025 With rtk_valid=1, rtk SHALL equal TK1[127:64]^TK2_rounding[127:64]^TK3[127:64], with {4'h0,rc[3:0]} XORed into bits 63:56 and {6'h0,rc[5:4]} XORed into bits 31:24.
REQ-026 With rtk_valid=0, rtk SHALL be 0.
REQ-027 The constant 0x02 on state row 2 SHALL be applied by the consumer, not by this block.
REQ-028 rtk_ready=0 in RUN SHALL hold all registers, with TK2_en=0 and rtk stable.
REQ-029 last_round SHALL equal (state==RUN && round_idx==NR-1).
REQ-030 Fire with last_round=1 SHALL go to IDLE with no register advance; busy SHALL be 0 on the next cycle.
REQ-031 start asserted on the final-fire cycle SHALL be ignored.
REQ-032 Outside LOAD and fire, TK2_en SHALL be 0 and TK2_sel SHALL be 0.
REQ-033 Latency SHALL be: start accepted at cycle t, first rtk_valid at t+2.

Reset
REQ-034 While rst_n=0 at a clock edge, state SHALL become IDLE and the TK1, TK3, rc and round_idx registers SHALL clear to 0.
REQ-035 Reset SHALL take effect mid-run: after the edge busy=0, rtk_valid=0, rtk=0, TK2_en=0, TK2_sel=0, round_idx=0 and last_round=0, and no residual handshake SHALL occur.

Structure
REQ-036 The shared package SHALL hold NR, the P table, the rc initial value 6'h01, and the FSM state encoding.
REQ-037 The block SHALL reuse the existing TweakPerm module for PT.
REQ-038 The block SHALL contain one new sub-module, LFSR3 (one W-bit cell), instantiated 8 times.

Verification
REQ-039 All-zero keys with TK2_rounding=0 and rtk_ready=1 SHALL give rtk 0x01000000_00000000 for round 0 and 0x0E000000_03000000 for round 5 (rc=0x3E).
REQ-040 TK1_init cells 00..0F with TK2 and TK3 zero SHALL give round-1 rtk 0x0A0F080D_0A0E0C0B.
REQ-041 rtk_ready held low 3 cycles in round 2 SHALL keep rtk and round_idx stable with TK2_en=0; round_idx SHALL advance to 3 one cycle after ready rises.
REQ-042 A full NR=40 run with ready high SHALL give 40 consecutive valid cycles, last_round only on round_idx=39, and busy=0 on the following cycle.
REQ-043 rst_n=0 at round 10 SHALL give IDLE with all outputs 0 on the next cycle; a later start SHALL restart at round 0 with rc 0x01.
REQ-044 start pulsed during RUN and on the final-fire cycle SHALL give no LOAD and no TK2_sel pulse.
